// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the programmable clock divider.
package clk_div_pkg;
  typedef enum logic {IDLE, PEND} state_t;
  localparam int RATIO_MIN   = 2;
  localparam int DEF_RATIO_W = 8;
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter and registered divided clock.
// Optional o_tick (last cycle of each running period) when CLK_DIV_CTRL_TICK_EN is defined.
module clk_div_core #(
  parameter int RATIO_W   = 8,
  parameter int RATIO_RST = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [RATIO_W-1:0] i_cur,
  input  logic [RATIO_W-1:0] i_nxt,
  input  logic               i_cnt_en,
  output logic               o_wrap,
`ifdef CLK_DIV_CTRL_TICK_EN
  output logic               o_tick,
`endif
  output logic               o_clk
);
  localparam logic [RATIO_W-1:0] CNT_RST = RATIO_W'(RATIO_RST - 1);
  localparam logic [RATIO_W-1:0] ONE     = RATIO_W'(1);
  logic [RATIO_W-1:0] r_cnt, w_cnt_nxt, w_last_nxt;
  assign o_wrap     = r_cnt == i_cur - ONE;
  assign w_last_nxt = i_nxt - ONE;
  // a stopped divider parks on the last count of whichever ratio is in force
  assign w_cnt_nxt  = !i_cnt_en ? w_last_nxt : o_wrap ? '0 : r_cnt + ONE;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= CNT_RST;
      o_clk <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      o_clk <= i_cnt_en && (w_cnt_nxt < (i_nxt >> 1));
    end
  end
`ifdef CLK_DIV_CTRL_TICK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_tick <= 1'b0;
    else          o_tick <= i_cnt_en && (w_cnt_nxt == w_last_nxt);
  end
`endif
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable divider with boundary-aligned ratio change and enable.
// Define CLK_DIV_CTRL_TICK_EN to add the o_tick end-of-period output.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int RATIO_W   = DEF_RATIO_W,
  parameter int RATIO_RST = 5
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [RATIO_W-1:0] i_ratio,
  input  logic               i_ratio_vld,
  output logic               o_ratio_rdy,
  output logic               o_err,
  output logic               o_busy,
`ifdef CLK_DIV_CTRL_TICK_EN
  output logic               o_tick,
`endif
  output logic               o_clk
);
  state_t             r_state, w_state_nxt;
  logic [RATIO_W-1:0] r_cur, r_pend, w_nxt;
  logic               r_err, w_wrap, w_cnt_en, w_acc, w_ok, w_apply;
  assign o_ratio_rdy = r_state == IDLE;
  assign o_busy      = r_state == PEND;
  assign o_err       = r_err;
  assign w_acc       = i_ratio_vld && o_ratio_rdy;
  assign w_ok        = i_ratio >= RATIO_W'(RATIO_MIN);
  assign w_cnt_en    = i_en || !w_wrap;
  // swap ratios only on a boundary edge, so no period is ever cut short
  assign w_apply     = (r_state == PEND) && w_wrap;
  assign w_nxt       = w_apply ? r_pend : r_cur;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (w_acc && w_ok) ? PEND : w_apply ? IDLE : r_state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cur   <= RATIO_W'(RATIO_RST);
      r_pend  <= RATIO_W'(RATIO_RST);
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_nxt;
      r_pend  <= (w_acc && w_ok) ? i_ratio : r_pend;
      r_err   <= w_acc && !w_ok;
    end
  end
  clk_div_core #(.RATIO_W(RATIO_W), .RATIO_RST(RATIO_RST)) u_core (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_cur    (r_cur),
    .i_nxt    (w_nxt),
    .i_cnt_en (w_cnt_en),
    .o_wrap   (w_wrap),
`ifdef CLK_DIV_CTRL_TICK_EN
    .o_tick   (o_tick),
`endif
    .o_clk    (o_clk)
  );
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench; a cycle model pushes expected outputs per edge.
module tb_clk_div_ctrl;
  logic       i_clk = 1'b0, i_rst_n = 1'b0, i_en = 1'b0, i_ratio_vld = 1'b0;
  logic [7:0] i_ratio = '0;
  logic       o_ratio_rdy, o_err, o_busy, o_clk;
`ifdef CLK_DIV_CTRL_TICK_EN
  logic       o_tick;
`endif
  typedef struct packed {logic clk, rdy, busy, err, tick;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int m_cur, m_cnt, m_pend, m_pst;

  clk_div_ctrl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_ratio(i_ratio),
    .i_ratio_vld(i_ratio_vld), .o_ratio_rdy(o_ratio_rdy), .o_err(o_err),
    .o_busy(o_busy),
`ifdef CLK_DIV_CTRL_TICK_EN
    .o_tick(o_tick),
`endif
    .o_clk(o_clk));

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0d exp=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_rst();
    m_cur = 5; m_cnt = 4; m_pend = 5; m_pst = 0;
  endtask

  // Spec-level model: advance one i_clk edge from the current inputs and push the outputs it predicts.
  task automatic model_step();
    exp_t e;
    int wrap, run, n_cur, n_cnt;
    wrap  = (m_cnt == m_cur - 1);
    run   = i_en || !wrap;
    n_cur = (m_pst && wrap) ? m_pend : m_cur;
    n_cnt = run ? (wrap ? 0 : m_cnt + 1) : n_cur - 1;
    e.clk  = run && (n_cnt < n_cur / 2);
    e.tick = run && (n_cnt == n_cur - 1);
    e.err  = !m_pst && i_ratio_vld && (int'(i_ratio) < 2);
    if (!m_pst && i_ratio_vld && int'(i_ratio) >= 2) begin
      m_pend = int'(i_ratio); m_pst = 1;
    end else if (m_pst && wrap) m_pst = 0;
    e.busy = m_pst[0];
    e.rdy  = !m_pst[0];
    m_cur = n_cur; m_cnt = n_cnt;
    q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge i_clk); #1;
    e = q.pop_front();
    check("o_clk", o_clk, e.clk);
    check("o_ratio_rdy", o_ratio_rdy, e.rdy);
    check("o_busy", o_busy, e.busy);
    check("o_err", o_err, e.err);
`ifdef CLK_DIV_CTRL_TICK_EN
    check("o_tick", o_tick, e.tick);
`endif
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic request(int r);
    i_ratio = 8'(r); i_ratio_vld = 1'b1;
    cycle();
    i_ratio_vld = 1'b0;
  endtask

  task automatic check_reset(string tag);
    check({tag, "_clk"}, o_clk, 0);
    check({tag, "_rdy"}, o_ratio_rdy, 1);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    int hi, errs, found;
    model_rst();
    repeat (3) @(posedge i_clk);
    #1 check_reset("rst");
    i_rst_n = 1'b1; i_en = 1'b1;
    // first period at ratio 5: rise one cycle after enable, 2 high / 3 low
    hi = 0;
    cycle();
    check("first_rise", o_clk, 1);
    hi += int'(o_clk);
    for (int i = 0; i < 4; i++) begin cycle(); hi += int'(o_clk); end
    check("r5_high_cycles", hi, 2);
    run(2);
    request(4);
    check("busy_after_req", o_busy, 1);
    run(12);
    hi = 0;
    for (int i = 0; i < 4; i++) begin cycle(); hi += int'(o_clk); end
    check("r4_high_cycles", hi, 2);
    // rejected ratios
    errs = 0;
    request(1); errs += int'(o_err);
    cycle();    errs += int'(o_err);
    request(0); errs += int'(o_err);
    cycle();    errs += int'(o_err);
    check("err_pulses", errs, 2);
    check("busy_after_rej", o_busy, 0);
    run(5);
    // request landing on the boundary cycle
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_cnt == m_cur - 1) found = 1; else cycle();
    end
    check("wait_boundary", found, 1);
    request(6);
    run(20);
    // stop at cnt=1 of ratio 6
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_cnt == 1) found = 1; else cycle();
    end
    check("wait_cnt1", found, 1);
    i_en = 1'b0;
    run(10);
    check("stopped_low", o_clk, 0);
    request(3);
    cycle();
    check("stopped_applied", o_ratio_rdy, 1);
    run(3);
    i_en = 1'b1;
    hi = 0;
    for (int i = 0; i < 9; i++) begin cycle(); hi += int'(o_clk); end
    check("r3_high_cycles", hi, 3);
    // reset while a request is pending
    request(7);
    check("busy_before_rst", o_busy, 1);
    i_rst_n = 1'b0;
    #1 check_reset("async_rst");
    model_rst();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 10; i++) begin cycle(); hi += int'(o_clk); end
    check("post_rst_r5_high", hi, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time programmable integer clock divider with a glitch-free ratio-change controller. Sits between a register/config master and the divided-clock consumers: accepts new divide ratios over a valid/ready handshake and applies them only on an output-period boundary, so o_clk never produces a runt pulse. Also provides a clean, period-aligned start/stop through an enable input.

## Interface
- RATIO_W, 8, width of ratio fields
- RATIO_RST, 5, divide ratio after reset; legal range 2..2^RATIO_W-1
- i_clk  in  1  source clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_en  in  1  divider enable; stops and starts only at period boundary
- i_ratio  in  RATIO_W  requested divide ratio
- i_ratio_vld  in  1  request valid
- o_ratio_rdy  out  1  controller can accept a request
- o_err  out  1  one-cycle pulse: rejected ratio (<2)
- o_busy  out  1  accepted ratio pending, not yet applied
- o_clk  out  1  divided clock, registered

## Operation
- Registers: cur (active ratio), cnt (0..cur-1), pend (pending ratio), state, o_clk.
- H = floor(cur/2). Period = cur i_clk cycles; o_clk high for H cycles, low for cur-H (N=5: 2 high/3 low; N=4: 2/2).
- cnt reaches cur-1 = last cycle of period ("boundary").
- Counting edge: cnt_next = (cnt==cur-1) ? 0 : cnt+1; o_clk <= (cnt_next < H_next), where H_next uses the ratio in force after the edge.
- Enable: counting edge occurs if i_en=1, or if cnt != cur-1 (a running period always completes). With i_en=0 at boundary: cnt holds cur-1, o_clk holds 0.
- FSM states: IDLE, PEND.
  - IDLE: o_ratio_rdy=1, o_busy=0. On vld&&rdy: ratio>=2 -> pend<=i_ratio, go PEND; ratio<2 -> o_err=1 next cycle, stay IDLE, request consumed.
  - PEND: o_ratio_rdy=0, o_busy=1. On a clock edge where cnt==cur-1 (running or stopped): cur<=pend, cnt->0 if counting else stays at pend-1; go IDLE.
- Arithmetic: cnt and cur RATIO_W bits unsigned; no overflow since cnt<cur<=2^RATIO_W-1.

## Timing
- Reset values: cur=RATIO_RST, cnt=RATIO_RST-1, o_clk=0, state=IDLE, o_ratio_rdy=1, o_busy=0, o_err=0.
- First enabled edge after reset release: cnt->0, o_clk rises 1 cycle after i_en sampled high.
- Request accept to o_busy=1: 1 cycle. o_ratio_rdy low the cycle after accept.
- Capture in same cycle that cnt==cur-1: new ratio does NOT apply at that boundary; it applies at the next boundary (latency <= 2*cur_old cycles).
- Stopped divider (i_en=0, at boundary): pending ratio applied on the edge after entering PEND; cnt set to new-1.
- Ratio applied: first period at new ratio begins at the same edge; o_ratio_rdy=1 the following cycle.
- o_err: exactly one cycle, registered, one cycle after the rejected handshake.
- i_en deasserted mid-period: current period completes; o_clk ends low, no truncated high phase.
- Reset asserted mid-operation: all registers to reset values immediately; pending request discarded.

## Configuration
- CLK_DIV_CTRL_TICK_EN defined: extra port o_tick (out, 1): registered, high for the one cycle in which cnt==cur-1 while i_en=1 (last cycle of each running period); reset 0.
- Undefined: o_tick port and its logic absent; all other behaviour identical.

## Structure
- Package clk_div_pkg: state enum (IDLE, PEND), constant RATIO_MIN=2, default RATIO_W.
- Sub-module clk_div_core: cnt, o_clk and boundary flag; inputs cur ratio, count-enable; output wrap (cnt==cur-1). clk_div_ctrl holds the FSM, pend, cur, o_err, and instantiates the core.

## Test plan
- Reset, RATIO_RST=5, i_en=1 after release -> o_clk period 50 ns at 10 ns i_clk, 20 ns high/30 ns low, first rise 1 cycle after enable.
- Request ratio 4 mid-period -> o_busy=1, current 5-cycle period completes, next period 4 cycles (2/2), o_ratio_rdy returns 1 cycle after switch.
- Request ratio 1 and 0 -> o_err one-cycle pulse each, ratio unchanged, o_busy stays 0.
- Request asserted exactly on boundary cycle -> one more period at old ratio, then new ratio; no runt pulse on o_clk.
- i_en dropped at cnt=1 of ratio 6 -> period completes, o_clk held 0; request ratio 3 while stopped -> applied next edge; i_en=1 -> 3-cycle periods (1 high/2 low).
- Assert i_rst_n low while PEND -> o_clk=0, o_busy=0, ratio back to 5; with CLK_DIV_CTRL_TICK_EN, o_tick pulses once per period, 0 during stop.
